// File: rtl/qclk_pkg.sv
// Shared types and the quadrature step decoder for the quadrature clock monitor.
// Phase encoding is {sck_0, sck_90}; forward rotation is 00 -> 10 -> 11 -> 01 -> 00.
package qclk_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StLocked  = 2'd2
    } qclk_state_e;

    localparam int unsigned MatchCntWidth = 4;

    function automatic logic [1:0] fwd_next(input logic [1:0] q);
        logic [1:0] nxt;
        unique case (q)
            2'b00:   nxt = 2'b10;
            2'b10:   nxt = 2'b11;
            2'b11:   nxt = 2'b01;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    function automatic logic is_fwd_step(input logic [1:0] q_prev, input logic [1:0] q);
        return (q == fwd_next(q_prev));
    endfunction

endpackage

// File: rtl/qclk_sync.sv
// Two-flop synchronizer bringing one quadrature input into the clk_in domain.
module qclk_sync (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/quadrature_clock_monitor.sv
// Measures the quarter period of a quadrature clock pair, tracks direction and position,
// and declares lock once successive quarter measurements agree.
module quadrature_clock_monitor
    import qclk_pkg::*;
#(
    parameter int unsigned DIVIDER_WIDTH = 8,
    parameter int unsigned LOCK_COUNT    = 4
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     sck_0,
    input  logic                     sck_90,
    input  logic                     clear,
    output logic [DIVIDER_WIDTH-1:0] quarter_count,
    output logic                     quarter_valid,
    output logic                     direction,
    output logic                     locked,
    output logic [15:0]              position,
    output logic                     phase_error
);
    localparam logic [DIVIDER_WIDTH-1:0] IntervalMax = '1;
    localparam logic [DIVIDER_WIDTH-1:0] IntervalOne = DIVIDER_WIDTH'(1);
    localparam logic [MatchCntWidth-1:0] LockCnt     = MatchCntWidth'(LOCK_COUNT);
    localparam logic [MatchCntWidth-1:0] MatchCntMax = '1;
    localparam logic [MatchCntWidth-1:0] MatchCntOne = MatchCntWidth'(1);

    logic       sck_0_s, sck_90_s;
    logic [1:0] q;

    qclk_sync u_sync_0 (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (sck_0),
        .sync_out (sck_0_s)
    );

    qclk_sync u_sync_90 (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (sck_90),
        .sync_out (sck_90_s)
    );

    // Edge-classification stage
    logic [1:0] q_prev_q, q_prev_d;
    logic       chg_q, chg_d;
    logic       err_q, err_d;
    logic       step_q, step_d;
    logic       step_fwd_q, step_fwd_d;

    always_comb begin
        q          = {sck_0_s, sck_90_s};
        q_prev_d   = q;
        chg_d      = (q != q_prev_q);
        err_d      = ((q ^ q_prev_q) == 2'b11);
        step_d     = chg_d && !err_d;
        step_fwd_d = is_fwd_step(q_prev_q, q);
    end

    // Measurement / lock stage
    qclk_state_e              state_q, state_d;
    logic [DIVIDER_WIDTH-1:0] interval_q, interval_d;
    logic [MatchCntWidth-1:0] match_cnt_q, match_cnt_d;
    logic                     prev_valid_q, prev_valid_d;
    logic [DIVIDER_WIDTH-1:0] quarter_count_q, quarter_count_d;
    logic                     quarter_valid_q, quarter_valid_d;
    logic                     direction_q, direction_d;
    logic                     locked_q, locked_d;
    logic [15:0]              position_q, position_d;
    logic                     phase_error_q, phase_error_d;

    logic                     saturated;
    logic                     match;
    logic [DIVIDER_WIDTH-1:0] diff;
    logic [MatchCntWidth-1:0] match_inc;

    always_comb begin
        state_d         = state_q;
        interval_d      = interval_q;
        match_cnt_d     = match_cnt_q;
        prev_valid_d    = prev_valid_q;
        quarter_count_d = quarter_count_q;
        quarter_valid_d = 1'b0;
        direction_d     = direction_q;
        position_d      = position_q;
        phase_error_d   = phase_error_q | err_q;

        saturated = (interval_q == IntervalMax);
        diff      = (interval_q >= quarter_count_q) ? (interval_q - quarter_count_q)
                                                    : (quarter_count_q - interval_q);
        match     = prev_valid_q && (diff <= IntervalOne) && (step_fwd_q == direction_q);
        match_inc = (match_cnt_q == MatchCntMax) ? match_cnt_q : (match_cnt_q + MatchCntOne);

        if (chg_q) begin
            interval_d = IntervalOne;
        end else if (!saturated) begin
            interval_d = interval_q + IntervalOne;
        end

        if (err_q) begin
            state_d      = StIdle;
            match_cnt_d  = '0;
            prev_valid_d = 1'b0;
        end else if (step_q) begin
            direction_d = step_fwd_q;
            position_d  = step_fwd_q ? (position_q + 16'd1) : (position_q - 16'd1);
            // A saturated interval has no trustworthy start point, same as coming from idle.
            if (state_q == StIdle || saturated) begin
                state_d      = StAcquire;
                match_cnt_d  = '0;
                prev_valid_d = 1'b0;
            end else begin
                quarter_count_d = interval_q;
                quarter_valid_d = 1'b1;
                prev_valid_d    = 1'b1;
                if (match) begin
                    match_cnt_d = match_inc;
                    if (match_inc >= LockCnt) begin
                        state_d = StLocked;
                    end
                end else begin
                    match_cnt_d = '0;
                    state_d     = StAcquire;
                end
            end
        end else if (saturated) begin
            state_d      = StIdle;
            match_cnt_d  = '0;
            prev_valid_d = 1'b0;
        end

        // A coincident illegal transition still sets the sticky flag.
        if (clear) begin
            phase_error_d = err_q;
            position_d    = '0;
        end

        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            q_prev_q        <= 2'b00;
            chg_q           <= 1'b0;
            err_q           <= 1'b0;
            step_q          <= 1'b0;
            step_fwd_q      <= 1'b0;
            state_q         <= StIdle;
            interval_q      <= '0;
            match_cnt_q     <= '0;
            prev_valid_q    <= 1'b0;
            quarter_count_q <= '0;
            quarter_valid_q <= 1'b0;
            direction_q     <= 1'b0;
            locked_q        <= 1'b0;
            position_q      <= '0;
            phase_error_q   <= 1'b0;
        end else begin
            q_prev_q        <= q_prev_d;
            chg_q           <= chg_d;
            err_q           <= err_d;
            step_q          <= step_d;
            step_fwd_q      <= step_fwd_d;
            state_q         <= state_d;
            interval_q      <= interval_d;
            match_cnt_q     <= match_cnt_d;
            prev_valid_q    <= prev_valid_d;
            quarter_count_q <= quarter_count_d;
            quarter_valid_q <= quarter_valid_d;
            direction_q     <= direction_d;
            locked_q        <= locked_d;
            position_q      <= position_d;
            phase_error_q   <= phase_error_d;
        end
    end

    assign quarter_count = quarter_count_q;
    assign quarter_valid = quarter_valid_q;
    assign direction     = direction_q;
    assign locked        = locked_q;
    assign position      = position_q;
    assign phase_error   = phase_error_q;

endmodule
